// File: rtl/piso_stream_pkg.sv
// piso_stream_pkg: FSM state type and sizing helper shared by piso_stream_mem
// and its beat selector.
package piso_stream_pkg;

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} piso_state_t;

   // Bits needed to hold a count from 0 to n inclusive (never less than 1).
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/piso_beat_sel.sv
// piso_beat_sel: combinational mux that picks the NLANES words of one beat
// from the stored word set, honouring the latched serial direction.
module piso_beat_sel
#(
   parameter int IWIDTH  = 10,
   parameter int NINPUTS = 8,
   parameter int NLANES  = 1,
   parameter int BIW     = 1
) (
   input  logic [NINPUTS-1:0][IWIDTH-1:0] words_i,
   input  logic [BIW-1:0]                 beat_i,
   input  logic                           dir_i,
   output logic [NLANES-1:0][IWIDTH-1:0]  beat_o
);

   // Word w sits at serial position w (dir=0) or NINPUTS-1-w (dir=1).
   always_comb begin
      beat_o = '0;
      for (int l = 0; l < NLANES; l++) begin
         for (int w = 0; w < NINPUTS; w++) begin
            if (int'(beat_i) * NLANES + l == (dir_i ? (NINPUTS - 1 - w) : w)) begin
               beat_o[l] = words_i[w];
            end
         end
      end
   end

endmodule

// File: rtl/piso_stream_mem.sv
// piso_stream_mem: parallel-in/serial-out buffer streaming NLANES words per beat.
// Optional synchronous clear port clr_i when PISO_STREAM_CLR_EN is defined.
module piso_stream_mem
   import piso_stream_pkg::*;
#(
   parameter int  IWIDTH  = 10,
   parameter int  NINPUTS = 8,
   parameter int  NLANES  = 1,
   localparam int NBEATS  = NINPUTS / NLANES,
   localparam int RW      = cnt_width(NBEATS)
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
`ifdef PISO_STREAM_CLR_EN
   input  logic                           clr_i,
`endif
   input  logic                           load_valid_i,
   output logic                           load_ready_o,
   input  logic [NINPUTS-1:0][IWIDTH-1:0] in_i,
   input  logic                           dir_i,
   output logic                           out_valid_o,
   input  logic                           out_ready_i,
   output logic [NLANES-1:0][IWIDTH-1:0]  out_o,
   output logic                           out_last_o,
   output logic [RW-1:0]                  remaining_o,
   output piso_state_t                    state_o
);

   localparam logic [RW-1:0] NBEATS_R = RW'(NBEATS);

   piso_state_t                    state_q, state_d;
   logic [NINPUTS-1:0][IWIDTH-1:0] words_q, words_d;
   logic                           dir_q, dir_d;
   logic [RW-1:0]                  rem_q, rem_d;
   logic [RW-1:0]                  beat_idx;
   logic [NLANES-1:0][IWIDTH-1:0]  beat_w;
   logic                           clr_w;

`ifdef PISO_STREAM_CLR_EN
   assign clr_w = clr_i;
`else
   assign clr_w = 1'b0;
`endif

   // Beats already accepted = index of the beat currently on out_o.
   assign beat_idx    = NBEATS_R - rem_q;
   assign out_last_o  = (state_q == SHIFT) && (rem_q == RW'(1));
   assign out_o       = (state_q == SHIFT) ? beat_w : '0;
   assign remaining_o = rem_q;
   assign state_o     = state_q;

   piso_beat_sel #(
      .IWIDTH  (IWIDTH),
      .NINPUTS (NINPUTS),
      .NLANES  (NLANES),
      .BIW     (RW)
   ) u_beat_sel (
      .words_i (words_q),
      .beat_i  (beat_idx),
      .dir_i   (dir_q),
      .beat_o  (beat_w)
   );

   always_comb begin
      state_d      = state_q;
      words_d      = words_q;
      dir_d        = dir_q;
      rem_d        = rem_q;
      out_valid_o  = 1'b0;
      load_ready_o = 1'b0;
      case (state_q)
         IDLE: begin
            load_ready_o = 1'b1;
         end
         SHIFT: begin
            out_valid_o  = 1'b1;
            load_ready_o = out_last_o && out_ready_i;
            if (out_ready_i && (rem_q != '0)) begin
               rem_d = rem_q - RW'(1);
               if (out_last_o) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (clr_w) load_ready_o = 1'b0;
      // A load accepted on the final beat overrides the return to IDLE.
      if (load_valid_i && load_ready_o) begin
         words_d = in_i;
         dir_d   = dir_i;
         rem_d   = NBEATS_R;
         state_d = SHIFT;
      end
      if (clr_w) begin
         state_d = IDLE;
         rem_d   = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         words_q <= '0;
         dir_q   <= 1'b0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         words_q <= words_d;
         dir_q   <= dir_d;
         rem_q   <= rem_d;
      end
   end

endmodule

// File: tb/tb_piso_stream_mem.sv
// tb_piso_stream_mem: scoreboard bench for piso_stream_mem (NLANES=2 main
// instance, NLANES=8 single-beat instance, clr checks under PISO_STREAM_CLR_EN).
module tb_piso_stream_mem;
   import piso_stream_pkg::*;

   localparam int IW = 10;
   localparam int NI = 8;
   localparam int NL = 2;
   localparam int NB = 4;
   localparam int RW = 3;
   localparam int EW = 1 + RW + NL * IW;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main DUT (NLANES=2) ----------------
   logic                      load_valid = 1'b0;
   logic                      dir        = 1'b0;
   logic                      out_ready  = 1'b0;
   logic                      clr        = 1'b0;
   logic [NI-1:0][IW-1:0]     in_w       = '0;
   logic                      load_ready, out_valid, out_last;
   logic [NL-1:0][IW-1:0]     out_w;
   logic [RW-1:0]             remaining;
   piso_state_t               state;

   piso_stream_mem #(.IWIDTH(IW), .NINPUTS(NI), .NLANES(NL)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
`ifdef PISO_STREAM_CLR_EN
      .clr_i        (clr),
`endif
      .load_valid_i (load_valid),
      .load_ready_o (load_ready),
      .in_i         (in_w),
      .dir_i        (dir),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_o        (out_w),
      .out_last_o   (out_last),
      .remaining_o  (remaining),
      .state_o      (state)
   );

   // ---------------- single-beat DUT (NLANES=8) ----------------
   logic                      load_valid8 = 1'b0;
   logic                      out_ready8  = 1'b0;
   logic [NI-1:0][IW-1:0]     in8         = '0;
   logic                      load_ready8, out_valid8, out_last8;
   logic [NI-1:0][IW-1:0]     out8;
   logic [0:0]                rem8;
   piso_state_t               state8;

   piso_stream_mem #(.IWIDTH(IW), .NINPUTS(NI), .NLANES(NI)) dut8 (
      .clk_i        (clk),
      .rst_ni       (rst_n),
`ifdef PISO_STREAM_CLR_EN
      .clr_i        (1'b0),
`endif
      .load_valid_i (load_valid8),
      .load_ready_o (load_ready8),
      .in_i         (in8),
      .dir_i        (1'b0),
      .out_valid_o  (out_valid8),
      .out_ready_i  (out_ready8),
      .out_o        (out8),
      .out_last_o   (out_last8),
      .remaining_o  (rem8),
      .state_o      (state8)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   // Entry = {last, remaining, lane1..lane0}
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] e;
   logic [EW-1:0] held;
   logic          stall_q    = 1'b0;
   int            beats_seen = 0;

   task automatic push_load(input logic [NI-1:0][IW-1:0] w, input logic d);
      for (int k = 0; k < NB; k++) begin
         logic [NL-1:0][IW-1:0] b;
         for (int l = 0; l < NL; l++) begin
            int p;
            p = k * NL + l;
            b[l] = d ? w[NI-1-p] : w[p];
         end
         exp_q.push_back({(k == NB - 1), RW'(NB - k), b});
      end
   endtask

   // Inputs change at posedge+1, so negedge values are those the next edge sees.
   always @(negedge clk) begin
      if (!rst_n || clr) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) check("hold", {out_valid, out_last, remaining, out_w}, {1'b1, held});
         if (!out_valid) begin
            check("idle_zero", {out_last, remaining, out_w}, '0);
            check("idle_ready", load_ready, 1'b1);
         end else begin
            check("shift_ready", load_ready, out_last && out_ready);
         end
         if (out_valid && out_ready) begin
            check("beat_pending", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("beat", {out_last, remaining, out_w}, e);
            end
            beats_seen++;
         end
         stall_q = out_valid && !out_ready;
         held    = {out_last, remaining, out_w};
      end
   end

   // ---------------- drivers ----------------
   int rdy_mode = 0;
   int rdy_cnt  = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ((rdy_cnt % 3) == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         rdy_cnt++;
      end
   end

   task automatic do_load(input logic [NI-1:0][IW-1:0] w, input logic d);
      int cyc;
      cyc = 0;
      @(posedge clk);
      #1;
      in_w       = w;
      dir        = d;
      load_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (load_ready || cyc > 100) break;
         cyc++;
      end
      check("load_timeout", cyc <= 100, 1'b1);
      if (load_ready) push_load(w, d);
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      dir        = ~d;
      for (int i = 0; i < NI; i++) in_w[i] = IW'($urandom_range(0, 1023));
   endtask

   task automatic wait_drain();
      int cyc;
      cyc = 0;
      forever begin
         @(negedge clk);
         if ((exp_q.size() == 0 && !out_valid) || cyc > 300) break;
         cyc++;
      end
      check("drain", cyc <= 300, 1'b1);
   endtask

   function automatic logic [NI-1:0][IW-1:0] ramp_up();
      logic [NI-1:0][IW-1:0] w;
      for (int i = 0; i < NI; i++) w[i] = IW'(i + 1);
      return w;
   endfunction

   function automatic logic [NI-1:0][IW-1:0] rand_words();
      logic [NI-1:0][IW-1:0] w;
      for (int i = 0; i < NI; i++) w[i] = IW'($urandom_range(0, 1023));
      return w;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      logic [NI-1:0][IW-1:0] w;
      int base;
      int cyc;

      #2;
      check("rst_valid", out_valid, 1'b0);
      check("rst_last", out_last, 1'b0);
      check("rst_rem", remaining, '0);
      check("rst_out", out_w, '0);
      check("rst_ready", load_ready, 1'b1);
      check("rst_state", state, IDLE);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Ascending set, dir=0, free-running consumer
      rdy_mode = 0;
      base = beats_seen;
      do_load(ramp_up(), 1'b0);
      check("lat1_valid", out_valid, 1'b1);
      check("lat1_out", out_w, {10'd2, 10'd1});
      check("lat1_rem", remaining, 3'd4);
      wait_drain();
      check("a_beats", beats_seen - base, 4);

      // Descending set, dir=1, stalling consumer: same serial order
      rdy_mode = 1;
      for (int i = 0; i < NI; i++) w[i] = IW'(8 - i);
      base = beats_seen;
      do_load(w, 1'b1);
      check("b_first", out_w, {10'd2, 10'd1});
      wait_drain();
      check("b_beats", beats_seen - base, 4);

      // Early reload is held off until the final beat, then no bubble
      rdy_mode = 0;
      do_load(ramp_up(), 1'b0);
      for (int i = 0; i < NI; i++) w[i] = 10'd1023;
      do_load(w, 1'b0);
      check("b2b_valid", out_valid, 1'b1);
      check("b2b_out", out_w, {10'd1023, 10'd1023});
      check("b2b_rem", remaining, 3'd4);
      wait_drain();

      // Random data/direction, random consumer, back-to-back
      rdy_mode = 2;
      for (int n = 0; n < 4; n++) do_load(rand_words(), 1'($urandom_range(0, 1)));
      wait_drain();

      // Asynchronous reset mid-stream after two beats
      rdy_mode = 0;
      base = beats_seen;
      do_load(rand_words(), 1'b0);
      cyc = 0;
      while (beats_seen < base + 2 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      check("rst_mid_reach", beats_seen >= base + 2, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("rst_mid_valid", out_valid, 1'b0);
      check("rst_mid_rem", remaining, '0);
      check("rst_mid_out", out_w, '0);
      check("rst_mid_state", state, IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      base = beats_seen;
      do_load(rand_words(), 1'b1);
      wait_drain();
      check("post_rst_beats", beats_seen - base, 4);

      // Single-beat configuration
      @(posedge clk);
      #1;
      in8         = ramp_up();
      load_valid8 = 1'b1;
      out_ready8  = 1'b1;
      @(negedge clk);
      check("nb1_ready", load_ready8, 1'b1);
      @(posedge clk);
      #1;
      load_valid8 = 1'b0;
      in8         = rand_words();
      @(negedge clk);
      check("nb1_valid", out_valid8, 1'b1);
      check("nb1_last", out_last8, 1'b1);
      check("nb1_rem", rem8, 1'b1);
      check("nb1_out", out8, ramp_up());
      check("nb1_state", state8, SHIFT);
      @(negedge clk);
      check("nb1_done_valid", out_valid8, 1'b0);
      check("nb1_done_rem", rem8, 1'b0);
      check("nb1_done_out", out8, '0);

`ifdef PISO_STREAM_CLR_EN
      // Clear mid-stream, then clear wins over a simultaneous load
      rdy_mode = 0;
      do_load(ramp_up(), 1'b0);
      @(posedge clk);
      #1;
      clr = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("clr_ready_shift", load_ready, 1'b0);
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) w[i] = 10'd1023;
      in_w       = w;
      load_valid = 1'b1;
      @(negedge clk);
      check("clr_valid", out_valid, 1'b0);
      check("clr_rem", remaining, '0);
      check("clr_out", out_w, '0);
      check("clr_state", state, IDLE);
      check("clr_ready_idle", load_ready, 1'b0);
      @(posedge clk);
      #1;
      clr        = 1'b0;
      load_valid = 1'b0;
      @(negedge clk);
      check("clr_beats_load", out_valid, 1'b0);
      check("clr_state_after", state, IDLE);
`endif

      check("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/piso_stream_mem.md
Name: piso_stream_mem

Overview:
- Parametrised parallel-in/serial-out buffer, successor to the team's pisoMem block.
- Captures NINPUTS words of IWIDTH bits in one load.
- Emits them NLANES words per beat over a valid/ready stream, with selectable direction and a last-beat flag.
- Sits between a parallel producer (block compute results) and a narrow serial consumer (UART/packetiser path).

Parameters:
- IWIDTH, 10: width of one word.
- NINPUTS, 8: words per load. Must be a multiple of NLANES.
- NLANES, 1: words per output beat. NBEATS = NINPUTS/NLANES.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-low.
- load_valid  in  1  producer offers a parallel word set.
- load_ready  out  1  block can accept a load this cycle.
- in  in  [NINPUTS][IWIDTH]  parallel words; sampled only on load handshake.
- dir  in  1  0: in[0] first; 1: in[NINPUTS-1] first. Sampled only on load handshake.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts beat.
- out  out  [NLANES][IWIDTH]  current beat; lane 0 holds the earliest word in serial order.
- out_last  out  1  current beat is the final beat of the load.
- remaining  out  $clog2(NBEATS+1)  beats not yet accepted, including the current one.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - out_valid=0, out_last=0, out=0, remaining=0, load_ready=1.
  - Storage is cleared to 0.
  - Reset mid-stream discards all pending beats.
- States are IDLE and SHIFT.
- IDLE:
  - load_ready=1, out_valid=0.
  - A load handshake stores in[], latches dir, sets remaining=NBEATS and moves to SHIFT.
  - The first beat is presented on out with out_valid=1 on the next cycle (latency 1).
- SHIFT:
  - out_valid=1.
  - Beat k (0-based) carries the words at serial positions k*NLANES .. k*NLANES+NLANES-1.
  - Serial position p maps to in[p] when dir=0 and to in[NINPUTS-1-p] when dir=1.
  - On a beat handshake (out_valid && out_ready): advance to the next beat and decrement remaining.
  - While out_ready=0: out, out_last and remaining are held stable (AXI-stream rule). No data loss.
- out_last=1 exactly when remaining==1 in SHIFT.
- Final beat handshake with no simultaneous load: go to IDLE; out_valid=0 and out=0 on the next cycle.
- load_ready in SHIFT is 1 only while out_last && out_ready, which allows a back-to-back reload.
  - If final-beat handshake and load handshake coincide: the new set is captured, state stays SHIFT, and beat 0 of the new set appears next cycle with no bubble.
- load_valid in SHIFT while load_ready=0: the load is ignored. The producer must hold load_valid until the handshake.
- NLANES=NINPUTS (NBEATS=1): every beat is last. Remaining sequence per load is 1→0.
- in[] and dir changes outside the load handshake have no effect.
- Width rules:
  - Data passes through unmodified. No arithmetic on data.
  - remaining never wraps below 0.

Optional Feature:
- Macro: PISO_STREAM_CLR_EN.
- Defined:
  - Adds input port clr (1 bit), synchronous, active-high.
  - clr=1 forces IDLE, out_valid=0, remaining=0 and out=0 at the next edge.
  - clr has priority over any load or beat handshake in the same cycle.
  - load_ready is forced to 0 while clr=1.
- Not defined:
  - Port absent; behaviour exactly as above.

Decomposition:
- Package piso_stream_pkg holds:
  - typedef enum logic {IDLE, SHIFT} piso_state_t;
  - localparam helper function for beat-count width.
- One sub-module: piso_beat_sel.
  - Combinational selector: stored words + beat index + dir → NLANES-word beat.
  - Keeps the FSM/counter module free of indexing logic.

Test Plan (IWIDTH=10, NINPUTS=8, NLANES=2 unless noted):
- Reset then load in=1..8 (in[i]=i+1), dir=0, out_ready=1 → beats {1,2},{3,4},{5,6},{7,8} on consecutive cycles starting 1 cycle after load; out_last on the 4th beat; remaining 4,3,2,1; out_valid=0 afterwards.
- Load in[i]=8-i, dir=1, out_ready toggling 1,0,0,1,... → beats {1,2},{3,4},{5,6},{7,8} with out/remaining held stable during stalls; no duplicated or dropped beats.
- Back-to-back loads: assert load_valid with in=all 1023 while the final beat of a previous load is accepted → next cycle out={1023,1023}, remaining=4, no idle gap.
- Load in SHIFT with out_last=0 → load_ready=0 and the data is ignored; the original sequence completes unchanged.
- rst low mid-stream after 2 beats → out_valid=0, remaining=0, out=0 immediately (asynchronous); after release a fresh load streams correctly.
- NLANES=8: load 1..8 → single beat {1..8} with out_last=1. With PISO_STREAM_CLR_EN, clr mid-stream with NLANES=2 → IDLE next edge, and clr beats a simultaneous load.
